// File: rtl/string_op_if.sv
// string_op_if: groups the control, status and buffer-port signals of the
// string operation engine.
//
//   go, op, length   : control register (level go, 2-bit op, 8-bit byte limit)
//   a_addr / a_word  : StringA word index and its combinational read data
//   b_addr / b_word  : StringB word index and its combinational read data
//   res_we, res_addr,
//   res_wdata        : one-cycle Result-buffer write port
//   busy, done,
//   result           : status and scalar result
//   dbg_state        : engine FSM state for observation
//
// The master modport is the controller/memory side; the slave modport is the
// engine.
interface string_op_if #(
   parameter int MAX_WORDS = 8
);
   localparam int AW = $clog2(MAX_WORDS);

   logic          go;
   logic [1:0]    op;
   logic [7:0]    length;
   logic [AW-1:0] a_addr;
   logic [31:0]   a_word;
   logic [AW-1:0] b_addr;
   logic [31:0]   b_word;
   logic          res_we;
   logic [AW-1:0] res_addr;
   logic [31:0]   res_wdata;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   logic [1:0]    dbg_state;

   modport master (
      output go, op, length, a_word, b_word,
      input  a_addr, b_addr, res_we, res_addr, res_wdata,
      input  busy, done, result, dbg_state
   );

   modport slave (
      input  go, op, length, a_word, b_word,
      output a_addr, b_addr, res_we, res_addr, res_wdata,
      output busy, done, result, dbg_state
   );
endinterface

// File: rtl/string_op_engine.sv
// string_op_engine: byte-serial string engine (strlen, strcmp, toupper).
//
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : string_op_if slave modport (control, buffer ports, status)
//
// Handshake: an operation starts on a 0->1 transition of go seen while IDLE.
// busy is high for every RUN cycle, one byte examined per cycle. done rises
// with the result on the terminating edge and stays high while go remains
// high; dropping go returns the engine to IDLE. res_we is a single-cycle
// strobe that only occurs during RUN of a toupper operation.
module string_op_engine #(
   parameter int MAX_WORDS = 8
) (
   input logic         clk,
   input logic         reset,
   string_op_if.slave  bus
);
   localparam int AW   = $clog2(MAX_WORDS);
   localparam int IW   = AW + 2;   // byte index width
   localparam int LW   = AW + 3;   // limit width, holds 4*MAX_WORDS
   localparam int MAXB = 4 * MAX_WORDS;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_STRLEN  = 2'd0;
   localparam logic [1:0] OP_STRCMP  = 2'd1;
   localparam logic [1:0] OP_RSVD    = 2'd3;

   logic [1:0]    state;
   logic          go_q;
   logic [1:0]    op_q;
   logic [LW-1:0] lim_q;
   logic [IW-1:0] idx;
   logic [31:0]   acc;
   logic [31:0]   result_q;

   logic          start;
   logic [LW-1:0] lim_in;
   logic [1:0]    lane;
   logic [7:0]    a_byte;
   logic [7:0]    b_byte;
   logic [7:0]    up_byte;
   logic [8:0]    diff9;
   logic [31:0]   word_next;
   logic          is_last;
   logic          term;
   logic          wr;
   logic [31:0]   res_next;

   assign start = bus.go & ~go_q;

   always_comb begin
      lim_in = LW'(MAXB);
      if (int'(bus.length) < MAXB) lim_in = LW'(bus.length);
   end

   assign lane    = idx[1:0];
   assign a_byte  = bus.a_word[{lane, 3'b000} +: 8];
   assign b_byte  = bus.b_word[{lane, 3'b000} +: 8];
   assign up_byte = (a_byte >= 8'h61 && a_byte <= 8'h7A) ? (a_byte - 8'h20) : a_byte;
   assign diff9   = {1'b0, a_byte} - {1'b0, b_byte};
   // Lanes are filled in order and acc is cleared after every write, so
   // OR-ing the new byte in leaves not-yet-filled lanes at zero.
   assign word_next = acc | ({24'd0, up_byte} << {lane, 3'b000});
   assign is_last   = ({1'b0, idx} == (lim_q - LW'(1)));

   always_comb begin
      term     = 1'b0;
      wr       = 1'b0;
      res_next = result_q;
      if (op_q == OP_RSVD) begin
         term     = 1'b1;
         res_next = 32'hFFFF_FFFF;
      end else if (lim_q == '0) begin
         term     = 1'b1;
         res_next = 32'd0;
      end else begin
         case (op_q)
            OP_STRLEN: begin
               if (a_byte == 8'd0) begin
                  term     = 1'b1;
                  res_next = 32'(idx);
               end else if (is_last) begin
                  term     = 1'b1;
                  res_next = 32'(lim_q);
               end
            end
            OP_STRCMP: begin
               if (a_byte != b_byte) begin
                  term     = 1'b1;
                  res_next = {{23{diff9[8]}}, diff9};
               end else if (a_byte == 8'd0 || is_last) begin
                  term     = 1'b1;
                  res_next = 32'd0;
               end
            end
            default: begin
               term     = (a_byte == 8'd0) || is_last;
               wr       = term || (lane == 2'd3);
               res_next = (a_byte == 8'd0) ? 32'(idx) : 32'(idx) + 32'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         go_q     <= 1'b1;
         op_q     <= 2'd0;
         lim_q    <= '0;
         idx      <= '0;
         acc      <= 32'd0;
         result_q <= 32'd0;
      end else begin
         go_q <= bus.go;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  op_q  <= bus.op;
                  lim_q <= lim_in;
                  idx   <= '0;
                  acc   <= 32'd0;
               end
            end
            ST_RUN: begin
               if (term) begin
                  state    <= ST_DONE;
                  result_q <= res_next;
               end else begin
                  idx <= idx + IW'(1);
                  acc <= wr ? 32'd0 : word_next;
               end
            end
            ST_DONE: begin
               if (!bus.go) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.a_addr    = (state == ST_RUN) ? idx[IW-1:2] : '0;
   assign bus.b_addr    = (state == ST_RUN) ? idx[IW-1:2] : '0;
   assign bus.res_we    = (state == ST_RUN) && wr;
   assign bus.res_addr  = bus.res_we ? idx[IW-1:2] : '0;
   assign bus.res_wdata = bus.res_we ? word_next : 32'd0;
   assign bus.busy      = (state == ST_RUN);
   assign bus.done      = (state == ST_DONE);
   assign bus.result    = result_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_string_op_engine.sv
module tb_string_op_engine;
   logic clk;
   logic reset;

   string_op_if #(.MAX_WORDS(8)) bus ();

   string_op_engine #(.MAX_WORDS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // string buffers (combinational read)
   logic [31:0] a_mem [8];
   logic [31:0] b_mem [8];
   logic [31:0] res_mem [8];
   assign bus.a_word = a_mem[bus.a_addr];
   assign bus.b_word = b_mem[bus.b_addr];

   int n_tests = 0;
   int n_fail  = 0;
   int tot_we  = 0;
   int we_bad  = 0;
   int max_a   = 0;

   // write monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.res_we) begin
         tot_we = tot_we + 1;
         res_mem[bus.res_addr] = bus.res_wdata;
         if (!bus.busy) we_bad = we_bad + 1;
      end
      if (bus.busy && int'(bus.a_addr) > max_a) max_a = int'(bus.a_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic load_a(input string s);
      for (int w = 0; w < 8; w++) a_mem[w] = 32'd0;
      for (int k = 0; k < s.len() && k < 32; k++) a_mem[k/4][8*(k%4) +: 8] = s[k];
   endtask

   task automatic load_b(input string s);
      for (int w = 0; w < 8; w++) b_mem[w] = 32'd0;
      for (int k = 0; k < s.len() && k < 32; k++) b_mem[k/4][8*(k%4) +: 8] = s[k];
   endtask

   // Raises go and waits (bounded) for done; go is left high.
   task automatic run_op(input logic [1:0] op, input logic [7:0] len,
                         output int cyc, output int wr, output int mx,
                         output logic [31:0] res, output bit ok);
      int we0;
      we0 = tot_we;
      bus.op = op;
      bus.length = len;
      max_a = 0;
      cyc = 0;
      ok = 1'b0;
      bus.go = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bus.busy) cyc++;
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
      end
      wr  = tot_we - we0;
      mx  = max_a;
      res = bus.result;
   endtask

   task automatic release_go(input string name);
      bus.go = 1'b0;
      @(negedge clk);
      check({name, "_done_clear"}, {31'd0, bus.done}, 32'd0);
   endtask

   // stimulus table
   typedef struct {
      logic [1:0]  op;
      logic [7:0]  length;
      string       a;
      string       b;
      logic [31:0] exp_res;
      int          exp_cyc;
      int          exp_wr;
      int          exp_max;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic set_vec(input int n, input logic [1:0] op, input logic [7:0] len,
                          input string a, input string b, input logic [31:0] r,
                          input int c, input int w, input int m);
      vecs[n].op = op;      vecs[n].length = len;
      vecs[n].a = a;        vecs[n].b = b;
      vecs[n].exp_res = r;  vecs[n].exp_cyc = c;
      vecs[n].exp_wr = w;   vecs[n].exp_max = m;
   endtask

   initial begin
      int cyc, wr, mx, we0;
      logic [31:0] res;
      bit ok;

      set_vec(0,  2'd0, 8'd32,  "abc", "", 32'd3, 4, 0, 0);
      set_vec(1,  2'd1, 8'd32,  "abd", "abc", 32'd1, 3, 0, 0);
      set_vec(2,  2'd1, 8'd32,  "abc", "abd", 32'hFFFF_FFFF, 3, 0, 0);
      set_vec(3,  2'd1, 8'd32,  "abc", "abc", 32'd0, 4, 0, 0);
      set_vec(4,  2'd0, 8'd0,   "abc", "", 32'd0, 1, 0, 0);
      set_vec(5,  2'd0, 8'd255, "abcdefghijklmnopqrstuvwxyzABCDEF", "", 32'd32, 32, 0, 7);
      set_vec(6,  2'd3, 8'd32,  "abc", "", 32'hFFFF_FFFF, 1, 0, 0);
      set_vec(7,  2'd0, 8'd4,   "abcdef", "", 32'd4, 4, 0, 0);
      set_vec(8,  2'd1, 8'd3,   "abcX", "abcY", 32'd0, 3, 0, 0);
      set_vec(9,  2'd2, 8'd32,  "az{\140", "", 32'd4, 5, 2, 1);
      set_vec(10, 2'd2, 8'd32,  "hello, W0rld!", "", 32'd13, 14, 4, 3);
      set_vec(11, 2'd1, 8'd32,  "a", "", 32'h61, 1, 0, 0);
      set_vec(12, 2'd2, 8'd2,   "hello", "", 32'd2, 2, 1, 0);
      set_vec(13, 2'd0, 8'd32,  "", "", 32'd0, 1, 0, 0);

      // reset with go held high
      reset = 1'b0;
      bus.go = 1'b1;
      bus.op = 2'd0;
      bus.length = 8'd32;
      load_a("abc");
      load_b("");
      for (int w = 0; w < 8; w++) res_mem[w] = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_res_we", {31'd0, bus.res_we}, 32'd0);
      check("rst_a_addr", 32'(bus.a_addr), 32'd0);
      check("rst_res_wdata", bus.res_wdata, 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("go_held_no_start", {31'd0, bus.busy | bus.done}, 32'd0);
      bus.go = 1'b0;
      @(negedge clk);

      // table-driven vectors
      for (int n = 0; n < NV; n++) begin
         load_a(vecs[n].a);
         load_b(vecs[n].b);
         run_op(vecs[n].op, vecs[n].length, cyc, wr, mx, res, ok);
         check($sformatf("v%0d_finished", n), {31'd0, ok}, 32'd1);
         check($sformatf("v%0d_result", n), res, vecs[n].exp_res);
         check($sformatf("v%0d_run_cycles", n), 32'(cyc), 32'(vecs[n].exp_cyc));
         check($sformatf("v%0d_writes", n), 32'(wr), 32'(vecs[n].exp_wr));
         check($sformatf("v%0d_max_addr", n), 32'(mx), 32'(vecs[n].exp_max));
         release_go($sformatf("v%0d", n));
      end

      // toupper buffer contents, then hold go high after done
      for (int w = 0; w < 8; w++) res_mem[w] = 32'hDEAD_BEEF;
      load_a("hello, W0rld!");
      run_op(2'd2, 8'd32, cyc, wr, mx, res, ok);
      check("up_finished", {31'd0, ok}, 32'd1);
      check("up_word0", res_mem[0], 32'h4C4C_4548);
      check("up_word1", res_mem[1], 32'h5720_2C4F);
      check("up_word2", res_mem[2], 32'h444C_5230);
      check("up_word3", res_mem[3], 32'h0000_0021);
      check("up_word4_untouched", res_mem[4], 32'hDEAD_BEEF);
      we0 = tot_we;
      repeat (5) @(negedge clk);
      check("hold_done", {31'd0, bus.done}, 32'd1);
      check("hold_not_busy", {31'd0, bus.busy}, 32'd0);
      check("hold_result", bus.result, 32'd13);
      check("hold_no_writes", 32'(tot_we - we0), 32'd0);
      release_go("hold");
      check("result_kept_in_idle", bus.result, 32'd13);

      // new edge starts a fresh operation
      load_a("abc");
      run_op(2'd0, 8'd32, cyc, wr, mx, res, ok);
      check("restart_result", res, 32'd3);
      release_go("restart");

      // reset in the middle of toupper
      load_a("abcdefghijklmnopqrstuvwxyzabcdef");
      we0 = tot_we;
      bus.op = 2'd2;
      bus.length = 8'd32;
      bus.go = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_busy", {31'd0, bus.busy}, 32'd1);
      check("mid_writes_before", 32'(tot_we - we0), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_res_we", {31'd0, bus.res_we}, 32'd0);
      check("mid_rst_a_addr", 32'(bus.a_addr), 32'd0);
      check("mid_rst_result", bus.result, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      we0 = tot_we;
      repeat (5) @(negedge clk);
      check("after_rst_no_writes", 32'(tot_we - we0), 32'd0);
      check("after_rst_idle", {31'd0, bus.busy | bus.done}, 32'd0);
      bus.go = 1'b0;
      @(negedge clk);
      run_op(2'd0, 8'd255, cyc, wr, mx, res, ok);
      check("after_rst_strlen", res, 32'd32);
      release_go("after_rst");

      check("we_only_in_run", 32'(we_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
